// File: rtl/ysyx_22050058_ifu.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction ROM and
// holds the fetched instruction in an IF/ID register with a valid/ready handshake.
module ysyx_22050058_ifu #(
   parameter int                 ADDR_W   = 64,
   parameter int                 INST_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0] rom_inst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              halted
);

   localparam logic [INST_W-1:0] EBREAK = INST_W'(32'h0010_0073);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic              vld_n;
   logic              capture;
   logic [ADDR_W-1:0] redirect_tgt;

   assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign rom_addr     = pc;
   assign rom_ce       = (state == S_FETCH);
   assign halted       = (state == S_HALT);

   always_comb begin
      state_n = state;
      pc_n    = pc;
      vld_n   = id_valid;
      capture = 1'b0;
      case (state)
         S_IDLE: begin
            state_n = S_FETCH;
         end
         S_FETCH: begin
            // A redirect discards whatever the ROM is presenting this cycle.
            if (redirect_valid) begin
               pc_n  = redirect_tgt;
               vld_n = 1'b0;
            end else if (!id_valid || id_ready) begin
               capture = 1'b1;
               vld_n   = 1'b1;
               pc_n    = pc + ADDR_W'(4);
               if (rom_inst == EBREAK) state_n = S_HALT;
            end
         end
         S_HALT: begin
            // An older branch may still squash the ebreak and restart fetch.
            if (redirect_valid) begin
               pc_n    = redirect_tgt;
               vld_n   = 1'b0;
               state_n = S_FETCH;
            end else if (id_valid && id_ready) begin
               vld_n = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         id_valid <= vld_n;
         if (capture) begin
            id_pc   <= pc;
            id_inst <= rom_inst;
         end
      end
   end

endmodule
